sccb_master: RTL and testbench

Parameterised SCCB/I2C-style master for camera register configuration, covering both register writes and register reads. It supports 8- or 16-bit register addresses, optional ACK checking with abort-on-NACK, and a read path that uses a stop/start split between phases, as SCCB requires. It sits between the camera register-table sequencer and the sensor's SCL/SDA pins. It is clocked by `dri_clk`, which runs at 4× the SCL frequency and is generated upstream.

---
 rtl/sccb_pkg.sv | 54 +++++
 rtl/sccb_if.sv | 24 ++
 rtl/sccb_byte_engine.sv | 101 ++++++++++
 rtl/sccb_master.sv | 191 +++++++++++++++++++
 tb/tb_sccb_master.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master: FSM states, byte-engine
// commands, quarter-phase encoding and the bus-level decode used per quarter.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_RECV,
    ST_STOP
  } state_e;

  typedef enum logic [1:0] {
    CMD_START,
    CMD_STOP,
    CMD_SEND,
    CMD_RECV
  } cmd_e;

  localparam int BIT_CYCLES  = 4;
  localparam int BYTE_CYCLES = 9 * BIT_CYCLES;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'(BIT_CYCLES - 1);

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // Returns {scl, sda} for one quarter of a segment; sda=1 means released.
  function automatic logic [1:0] bus_level(cmd_e cmd, logic [1:0] qtr,
                                           logic [3:0] bit_idx, logic tx_bit);
    logic scl_hi;
    logic [1:0] lvl;
    scl_hi = (qtr == Q1) || (qtr == Q2);
    case (cmd)
      CMD_START: begin
        if (qtr == Q0)      lvl = 2'b11;
        else if (qtr == Q3) lvl = 2'b00;
        else                lvl = 2'b10;
      end
      CMD_STOP: begin
        if (qtr == Q0)      lvl = 2'b00;
        else if (qtr == Q1) lvl = 2'b10;
        else                lvl = 2'b11;
      end
      CMD_SEND: lvl = {scl_hi, (bit_idx == 4'd8) ? 1'b1 : tx_bit};
      default:  lvl = {scl_hi, 1'b1};
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sccb_if.sv
// Request/response bundle between the register-table sequencer and the master.
// Handshake: exec is a request that is only taken while busy is low; the
// accept edge raises busy, and done pulses for one cycle as busy falls, with
// rd_data and ack_err valid from that cycle until the next accept.
interface sccb_if;
  logic        exec;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic        ack_err;

  modport master (
    output exec, rw, addr, wr_data,
    input  rd_data, busy, done, ack_err
  );

  modport slave (
    input  exec, rw, addr, wr_data,
    output rd_data, busy, done, ack_err
  );
endinterface

// File: rtl/sccb_byte_engine.sv
// Bit-level engine: runs one START, STOP, SEND or RECV segment on SCL/SDA
// using a quarter counter and bit counter, with registered pin outputs.
module sccb_byte_engine
  import sccb_pkg::*;
(
  input  logic       dri_clk,
  input  logic       rst_n,
  input  logic       start,
  input  cmd_e       cmd,
  input  logic [7:0] tx_byte,
  input  logic       sda_in,
  output logic       step_done,
  output logic       ack_bit,
  output logic [7:0] rx_byte,
  output logic       scl,
  output logic       sda_oe
);

  logic       active_q, active_d;
  cmd_e       cmd_q, cmd_d;
  logic [1:0] qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_q, rx_d;
  logic       ack_q, ack_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       last_bit;
  logic [1:0] lvl;

  assign last_bit  = (cmd_q == CMD_START) || (cmd_q == CMD_STOP) || (bit_q == 4'd8);
  assign step_done = active_q && (qtr_q == Q3) && last_bit;

  always_comb begin
    active_d = active_q;
    cmd_d    = cmd_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    ack_d    = ack_q;

    // The next segment is loaded on the edge that ends the last quarter, so
    // consecutive segments abut with no idle cycle between them.
    if (start) begin
      active_d = 1'b1;
      cmd_d    = cmd;
      qtr_d    = Q0;
      bit_d    = 4'd0;
      sh_d     = tx_byte;
    end else if (step_done) begin
      active_d = 1'b0;
    end else if (active_q) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == Q3) begin
        bit_d = bit_q + 4'd1;
        sh_d  = {sh_q[6:0], 1'b0};
      end
    end

    if (active_q && (qtr_q == Q2)) begin
      if ((cmd_q == CMD_RECV) && (bit_q < 4'd8)) rx_d = {rx_q[6:0], sda_in};
      if (bit_q == 4'd8) ack_d = sda_in;
    end

    // Pins are registered from the upcoming position so they change cleanly on the edge.
    lvl      = active_d ? bus_level(cmd_d, qtr_d, bit_d, sh_d[7]) : 2'b11;
    scl_d    = lvl[1];
    sda_oe_d = ~lvl[0];
  end

  always_ff @(posedge dri_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cmd_q    <= CMD_START;
      qtr_q    <= Q0;
      bit_q    <= 4'd0;
      sh_q     <= 8'h00;
      rx_q     <= 8'h00;
      ack_q    <= 1'b1;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      active_q <= active_d;
      cmd_q    <= cmd_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      ack_q    <= ack_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
    end
  end

  assign ack_bit = ack_q;
  assign rx_byte = rx_q;
  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: rtl/sccb_master.sv
// SCCB register-access master: sequences START/bytes/STOP for writes and the
// split write-then-read transaction, capturing the request on accept.
module sccb_master
  import sccb_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned ADDR_BYTES = 2,
  parameter bit          ACK_CHECK  = 1'b1
) (
  input  logic   dri_clk,
  input  logic   rst_n,
  sccb_if.slave  cfg,
  output logic   scl,
  inout  wire    sda,
  output state_e dbg_state
);

  localparam logic [1:0] AB = 2'(ADDR_BYTES);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wr_q, wr_d;
  logic [7:0]  rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;

  logic        eng_start;
  cmd_e        eng_cmd;
  logic [7:0]  eng_byte;
  logic        step_done;
  logic        ack_bit;
  logic [7:0]  rx_byte;
  logic        sda_oe;
  logic        sda_in;
  logic        nack;
  logic [1:0]  last_idx;

  // Byte order within a phase: device byte, address bytes (high first), data.
  function automatic logic [7:0] byte_at(logic ph, logic [1:0] idx,
                                         logic [15:0] a, logic [7:0] wd);
    logic [7:0] b;
    if (ph)                            b = {SLAVE_ADDR, OP_READ};
    else if (idx == 2'd0)              b = {SLAVE_ADDR, OP_WRITE};
    else if (idx == AB)                b = a[7:0];
    else if (idx == 2'd1)              b = a[15:8];
    else                               b = wd;
    return b;
  endfunction

  assign nack     = ACK_CHECK && ack_bit;
  assign last_idx = (rw_q == OP_READ) ? AB : AB + 2'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    eng_start = 1'b0;
    eng_cmd   = CMD_START;

    case (state_q)
      ST_IDLE: begin
        if (cfg.exec) begin
          state_d   = ST_START;
          idx_d     = 2'd0;
          phase_d   = 1'b0;
          rw_d      = cfg.rw;
          addr_d    = cfg.addr;
          wr_d      = cfg.wr_data;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          eng_start = 1'b1;
          eng_cmd   = CMD_START;
        end
      end
      ST_START: begin
        if (step_done) begin
          state_d   = ST_SEND;
          eng_start = 1'b1;
          eng_cmd   = CMD_SEND;
        end
      end
      ST_SEND: begin
        if (step_done) begin
          eng_start = 1'b1;
          if (nack) begin
            ack_err_d = 1'b1;
            state_d   = ST_STOP;
            eng_cmd   = CMD_STOP;
          end else if (phase_q) begin
            state_d = ST_RECV;
            eng_cmd = CMD_RECV;
          end else if (idx_q == last_idx) begin
            state_d = ST_STOP;
            eng_cmd = CMD_STOP;
          end else begin
            idx_d   = idx_q + 2'd1;
            eng_cmd = CMD_SEND;
          end
        end
      end
      ST_RECV: begin
        if (step_done) begin
          state_d   = ST_STOP;
          eng_start = 1'b1;
          eng_cmd   = CMD_STOP;
        end
      end
      ST_STOP: begin
        if (step_done) begin
          if (!phase_q && (rw_q == OP_READ) && !ack_err_q) begin
            phase_d   = 1'b1;
            idx_d     = 2'd0;
            state_d   = ST_START;
            eng_start = 1'b1;
            eng_cmd   = CMD_START;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (phase_q && !ack_err_q) rd_d = rx_byte;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    eng_byte = byte_at(phase_d, idx_d, addr_q, wr_q);
  end

  always_ff @(posedge dri_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      phase_q   <= 1'b0;
      rw_q      <= OP_WRITE;
      addr_q    <= 16'h0000;
      wr_q      <= 8'h00;
      rd_q      <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  sccb_byte_engine u_engine (
    .dri_clk   (dri_clk),
    .rst_n     (rst_n),
    .start     (eng_start),
    .cmd       (eng_cmd),
    .tx_byte   (eng_byte),
    .sda_in    (sda_in),
    .step_done (step_done),
    .ack_bit   (ack_bit),
    .rx_byte   (rx_byte),
    .scl       (scl),
    .sda_oe    (sda_oe)
  );

  // Open-drain pin: only ever pulled low, released otherwise.
  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign cfg.rd_data = rd_q;
  assign cfg.busy    = busy_q;
  assign cfg.done    = done_q;
  assign cfg.ack_err = ack_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: three parameter variants share one bus
// decoder / slave model, selected per test, with cycle-accurate done checks.
module tb_sccb_master;
  import sccb_pkg::*;

  localparam logic [10:0] EV_START = 11'h200;
  localparam logic [10:0] EV_STOP  = 11'h400;

  logic        dri_clk = 1'b0;
  logic        rst_n;
  logic [2:0]  exec_v;
  logic        rw_s;
  logic [15:0] addr_s;
  logic [7:0]  wd_s;
  int          sel;
  int          nack_k;
  logic [7:0]  slave_val;
  logic        mon_clr;

  int errors = 0;
  int checks = 0;

  sccb_if ifa ();
  sccb_if ifb ();
  sccb_if ifc ();
  wire    sda_a, sda_b, sda_c;
  logic   scl_a, scl_b, scl_c;
  state_e dbg_a, dbg_b, dbg_c;
  pullup (sda_a);
  pullup (sda_b);
  pullup (sda_c);

  assign ifa.exec = exec_v[0]; assign ifa.rw = rw_s; assign ifa.addr = addr_s; assign ifa.wr_data = wd_s;
  assign ifb.exec = exec_v[1]; assign ifb.rw = rw_s; assign ifb.addr = addr_s; assign ifb.wr_data = wd_s;
  assign ifc.exec = exec_v[2]; assign ifc.rw = rw_s; assign ifc.addr = addr_s; assign ifc.wr_data = wd_s;

  sccb_master #(.SLAVE_ADDR(7'h3C), .ADDR_BYTES(2), .ACK_CHECK(1'b1)) dut_a (
    .dri_clk(dri_clk), .rst_n(rst_n), .cfg(ifa), .scl(scl_a), .sda(sda_a), .dbg_state(dbg_a));
  sccb_master #(.SLAVE_ADDR(7'h3C), .ADDR_BYTES(2), .ACK_CHECK(1'b0)) dut_b (
    .dri_clk(dri_clk), .rst_n(rst_n), .cfg(ifb), .scl(scl_b), .sda(sda_b), .dbg_state(dbg_b));
  sccb_master #(.SLAVE_ADDR(7'h3C), .ADDR_BYTES(1), .ACK_CHECK(1'b1)) dut_c (
    .dri_clk(dri_clk), .rst_n(rst_n), .cfg(ifc), .scl(scl_c), .sda(sda_c), .dbg_state(dbg_c));

  // Clock / reset block
  always #5 dri_clk = ~dri_clk;

  // Bus decoder and slave model on the selected DUT's pins
  logic       drv_low = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         cnt = 0;
  int         byte_no = 0;
  logic [8:0] shr = 9'h000;
  logic [7:0] first_b = 8'h00;
  logic [10:0] mon_q[$];
  logic [10:0] exp_q[$];
  logic       scl_m, sda_m;

  assign scl_m = (sel == 0) ? scl_a : (sel == 1) ? scl_b : scl_c;
  assign sda_m = (sel == 0) ? sda_a : (sel == 1) ? sda_b : sda_c;
  assign sda_a = (sel == 0 && drv_low) ? 1'b0 : 1'bz;
  assign sda_b = (sel == 1 && drv_low) ? 1'b0 : 1'bz;
  assign sda_c = (sel == 2 && drv_low) ? 1'b0 : 1'bz;

  always @(negedge dri_clk) begin : mon
    int c;
    int bn;
    logic [8:0] s;
    logic [7:0] fb;
    logic tx;
    c = cnt; bn = byte_no; s = shr; fb = first_b;
    if (mon_clr) begin
      mon_q.delete();
      cnt <= 0; byte_no <= 0; shr <= 9'h000; first_b <= 8'h00;
      drv_low <= 1'b0; prev_scl <= 1'b1; prev_sda <= 1'b1;
    end else begin
      if (scl_m && !prev_scl) begin
        s = {s[7:0], sda_m};
        c = c + 1;
        if (c == 9) begin
          mon_q.push_back({2'b00, s[0], s[8:1]});
          if (bn == 0) fb = s[8:1];
          bn = bn + 1;
          c = 0;
        end
      end else if (scl_m && prev_scl && prev_sda && !sda_m) begin
        mon_q.push_back(EV_START);
        c = 0; bn = 0;
      end else if (scl_m && prev_scl && !prev_sda && sda_m) begin
        mon_q.push_back(EV_STOP);
        c = 0;
      end
      if (!scl_m) begin
        tx = (bn == 1) && (fb == 8'h79);
        if (tx && c < 8)                          drv_low <= !slave_val[3'(7 - c)];
        else if (!tx && c == 8 && bn + 1 != nack_k) drv_low <= 1'b1;
        else                                      drv_low <= 1'b0;
      end
      cnt <= c; byte_no <= bn; shr <= s; first_b <= fb;
      prev_scl <= scl_m; prev_sda <= sda_m;
    end
  end

  // Scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ev_b(input logic [7:0] d);
    return {3'b000, d};
  endfunction

  function automatic logic [10:0] ev_n(input logic [7:0] d);
    return {3'b001, d};
  endfunction

  task automatic check_log(input string tag);
    logic [10:0] o;
    check({tag, " len"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < mon_q.size()) ? mon_q[i] : 11'h7FF;
      check($sformatf("%s ev%0d", tag, i), 32'(o), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic mon_clear();
    @(posedge dri_clk); #2; mon_clr = 1'b1;
    @(posedge dri_clk); #2; mon_clr = 1'b0;
  endtask

  // Driver tasks
  task automatic start_txn(input int d, input logic r, input logic [15:0] a, input logic [7:0] wd);
    @(posedge dri_clk); #2;
    rw_s = r; addr_s = a; wd_s = wd; exec_v[d] = 1'b1;
    @(posedge dri_clk); #1;
    exec_v[d] = 1'b0;
    check($sformatf("busy_on d%0d", d), 32'((d == 0) ? ifa.busy : (d == 1) ? ifb.busy : ifc.busy), 32'd1);
  endtask

  task automatic wait_done(input int d, input int exp_l, input int poke_at, input string tag);
    int n;
    logic dn;
    n = 0;
    dn = 1'b0;
    while (!dn && n < 400) begin
      @(posedge dri_clk); #1;
      n++;
      if (n == poke_at) begin
        exec_v[d] = 1'b1; rw_s = 1'b1; addr_s = 16'hFFFF; wd_s = 8'h00;
      end
      if (n == poke_at + 1) exec_v[d] = 1'b0;
      dn = (d == 0) ? ifa.done : (d == 1) ? ifb.done : ifc.done;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_l));
    check({tag, " busy_off"}, 32'((d == 0) ? ifa.busy : (d == 1) ? ifb.busy : ifc.busy), 32'd0);
    @(posedge dri_clk); #1;
    check({tag, " done_pulse"}, 32'((d == 0) ? ifa.done : (d == 1) ? ifb.done : ifc.done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; exec_v = 3'b000; rw_s = 1'b0; addr_s = 16'h0000; wd_s = 8'h00;
    sel = 0; nack_k = 0; slave_val = 8'h56; mon_clr = 1'b1;
    repeat (3) @(posedge dri_clk);
    #1;
    check("rst scl", 32'(scl_a), 32'd1);
    check("rst sda", 32'(sda_a), 32'd1);
    check("rst busy", 32'(ifa.busy), 32'd0);
    check("rst done", 32'(ifa.done), 32'd0);
    check("rst ack_err", 32'(ifa.ack_err), 32'd0);
    check("rst rd_data", 32'(ifa.rd_data), 32'h00);
    check("rst state", 32'(dbg_a), 32'(ST_IDLE));
    #1; rst_n = 1'b1; mon_clr = 1'b0;

    // 16-bit address write, slave ACKs every byte
    mon_clear();
    start_txn(0, 1'b0, 16'h3008, 8'h82);
    wait_done(0, 152, -10, "wr16");
    check("wr16 ack_err", 32'(ifa.ack_err), 32'd0);
    exp_q = '{EV_START, ev_b(8'h78), ev_b(8'h30), ev_b(8'h08), ev_b(8'h82), EV_STOP};
    check_log("wr16");

    // Read with stop/start split; master NACKs the received byte
    mon_clear();
    start_txn(0, 1'b1, 16'h300A, 8'h00);
    wait_done(0, 196, -10, "rd16");
    check("rd16 rd_data", 32'(ifa.rd_data), 32'h56);
    check("rd16 ack_err", 32'(ifa.ack_err), 32'd0);
    exp_q = '{EV_START, ev_b(8'h78), ev_b(8'h30), ev_b(8'h0A), EV_STOP,
              EV_START, ev_b(8'h79), ev_n(8'h56), EV_STOP};
    check_log("rd16");

    // NACK on byte 2 aborts with ACK checking enabled
    nack_k = 2;
    mon_clear();
    start_txn(0, 1'b0, 16'h3008, 8'h82);
    wait_done(0, 80, -10, "nack");
    check("nack ack_err", 32'(ifa.ack_err), 32'd1);
    check("nack rd_data", 32'(ifa.rd_data), 32'h56);
    exp_q = '{EV_START, ev_b(8'h78), ev_n(8'h30), EV_STOP};
    check_log("nack");

    // Same NACK ignored when ACK checking is off
    sel = 1;
    mon_clear();
    start_txn(1, 1'b0, 16'h3008, 8'h82);
    wait_done(1, 152, -10, "nochk");
    check("nochk ack_err", 32'(ifb.ack_err), 32'd0);
    exp_q = '{EV_START, ev_b(8'h78), ev_n(8'h30), ev_b(8'h08), ev_b(8'h82), EV_STOP};
    check_log("nochk");
    nack_k = 0;

    // 8-bit address variant
    sel = 2;
    mon_clear();
    start_txn(2, 1'b0, 16'h0012, 8'hA5);
    wait_done(2, 116, -10, "wr8");
    check("wr8 ack_err", 32'(ifc.ack_err), 32'd0);
    exp_q = '{EV_START, ev_b(8'h78), ev_b(8'h12), ev_b(8'hA5), EV_STOP};
    check_log("wr8");

    // exec pulsed mid-transfer with changed inputs is ignored
    sel = 0;
    mon_clear();
    start_txn(0, 1'b0, 16'h3008, 8'h82);
    wait_done(0, 152, 50, "busyexec");
    check("busyexec rd_data", 32'(ifa.rd_data), 32'h56);
    exp_q = '{EV_START, ev_b(8'h78), ev_b(8'h30), ev_b(8'h08), ev_b(8'h82), EV_STOP};
    check_log("busyexec");

    // Asynchronous reset at cycle 70 while the master drives SDA low
    start_txn(0, 1'b0, 16'h1234, 8'h5A);
    repeat (69) @(posedge dri_clk);
    #3; rst_n = 1'b0; #1;
    check("midrst scl", 32'(scl_a), 32'd1);
    check("midrst sda", 32'(sda_a), 32'd1);
    check("midrst busy", 32'(ifa.busy), 32'd0);
    check("midrst rd_data", 32'(ifa.rd_data), 32'h00);
    check("midrst state", 32'(dbg_a), 32'(ST_IDLE));
    @(posedge dri_clk); #2; rst_n = 1'b1;

    // Normal read after reset
    slave_val = 8'h9C;
    mon_clear();
    start_txn(0, 1'b1, 16'h300A, 8'h00);
    wait_done(0, 196, -10, "postrst");
    check("postrst rd_data", 32'(ifa.rd_data), 32'h9C);
    exp_q = '{EV_START, ev_b(8'h78), ev_b(8'h30), ev_b(8'h0A), EV_STOP,
              EV_START, ev_b(8'h79), ev_n(8'h9C), EV_STOP};
    check_log("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
